// File: rtl/rand_arb_pkg.sv
// Shared types, constants and round-robin search for the random-value arbiter.
package rand_arb_pkg;

  localparam int unsigned LFSR_W  = 3;
  localparam int unsigned MAX_REQ = 8;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 3'b001;
  // Loaded instead of an all-zero seed, which would lock the LFSR up.
  localparam logic [LFSR_W-1:0] LOCKUP_SUB   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOAD
  } arb_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set request at or after (last+1) mod nreq, wrapping around.
  function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last,
                                         input int unsigned        nreq);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < nreq) begin
        idx = (32'(last) + 32'd1 + i) % nreq;
        if (!r.valid && req[idx]) begin
          r.valid = 1'b1;
          r.idx   = idx[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rand_arb_lfsr.sv
// Fibonacci LFSR with synchronous reseed; an all-zero seed is replaced.
module rand_lfsr
  import rand_arb_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             adv,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] lfsr_d, lfsr_q;

  // Next value: reseed has priority over advance.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? WIDTH'(LOCKUP_SUB) : seed;
    end else if (adv) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-2]};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out one LFSR value per registered grant.
// Optional grant counter enabled by defining RAND_ARB_STATS_EN.
module rand_arbiter
  import rand_arb_pkg::*;
#(
  parameter int unsigned      NREQ  = 4,
  parameter int unsigned      WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] q,
  output logic             busy
`ifdef RAND_ARB_STATS_EN
  ,
  output logic [7:0]       grant_cnt
`endif
);

  arb_state_e         state_d, state_q;
  logic [NREQ-1:0]    gnt_d, gnt_q;
  logic [WIDTH-1:0]   q_d, q_q;
  logic [2:0]         last_d, last_q;
  logic [WIDTH-1:0]   lfsr_val;
  logic               adv;
  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  rand_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (seed),
    .adv   (adv),
    .q     (lfsr_val)
  );

  // Widen requests to the search function's fixed width.
  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
    pick              = rr_search(req_ext, last_q, NREQ);
  end

  // Next state, grant and value capture; load overrides every request.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    q_d     = '0;
    last_d  = last_q;
    adv     = 1'b0;
    if (load) begin
      state_d = ST_LOAD;
    end else if (state_q == ST_LOAD) begin
      state_d = ST_IDLE;
    end else if (pick.valid) begin
      state_d = ST_GRANT;
      gnt_d   = NREQ'(1) << pick.idx;
      q_d     = lfsr_val;
      last_d  = pick.idx;
      adv     = 1'b1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // State, grant, value and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      q_q     <= '0;
      last_q  <= 3'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      last_q  <= last_d;
    end
  end

  assign gnt  = gnt_q;
  assign q    = q_q;
  assign busy = (state_q == ST_LOAD);

`ifdef RAND_ARB_STATS_EN
  logic [7:0] cnt_d, cnt_q;

  // Saturating grant count, held at zero while reseeding.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ST_LOAD)               cnt_d = '0;
    else if (adv && (cnt_q != 8'hFF))     cnt_d = cnt_q + 8'd1;
  end

  // Grant counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the generator (2..8).
REQ-002 Parameter WIDTH, default 3, random value width; the feedback polynomial is fixed for 3.
REQ-003 Parameter SEED, default 3'b001, value loaded at reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load  input  1  reseed request, level-sensitive.
REQ-007 seed  input  WIDTH  reseed value, sampled while load=1.
REQ-008 req  input  NREQ  per-requester request, held until granted.
REQ-009 gnt  output  NREQ  one-hot grant pulse, registered.
REQ-010 q  output  WIDTH  random value, valid only in the cycle gnt is nonzero.
REQ-011 busy  output  1  high while FSM is in LOAD.

Function
REQ-012 The block SHALL contain one Fibonacci LFSR with q_next = {q[2], q[1], q[3]^q[2]} (bits numbered [3:1]), which has period 7 from any nonzero state.
REQ-013 FSM states SHALL be IDLE, GRANT and LOAD, encoded as a shared enum.
REQ-014 In IDLE or GRANT with load=0, if any req bit is set, the next state SHALL be GRANT; otherwise the next state SHALL be IDLE.
REQ-015 In GRANT, gnt SHALL be one-hot for exactly one cycle, and q SHALL equal the LFSR state before advance.
REQ-016 The LFSR SHALL advance on the same edge that registers a grant, and only then.
REQ-017 Arbitration SHALL be round-robin: search starts at index (last_granted+1) mod NREQ, and last_granted resets to NREQ-1 so index 0 wins first.
REQ-018 Grant latency SHALL be 1 cycle, meaning a req sampled at edge N produces gnt during cycle N+1.
REQ-019 Back-to-back grants on consecutive cycles SHALL be supported.
REQ-020 A requester that keeps req high after its gnt SHALL be re-arbitrated normally and SHALL NOT be granted twice in a row while others request.
REQ-021 load=1 in any state SHALL force LOAD on the next edge, with priority over all requests.
REQ-022 While in LOAD, gnt SHALL be 0 and the LFSR SHALL be loaded with seed each cycle.
REQ-023 If seed==0, the LFSR SHALL load 3'b001 to avoid lock-up.
REQ-024 On load deassertion, the FSM SHALL go from LOAD to IDLE, and pending requests SHALL be served from the following edge.
REQ-025 A request present during LOAD SHALL be neither lost nor granted; it is served after exit while still held.
REQ-026 The round-robin pointer SHALL be unaffected by load.

Reset
REQ-027 rst_n=0 SHALL asynchronously set state=IDLE, LFSR=SEED, gnt=0, q=0, busy=0 and last_granted=NREQ-1.
REQ-028 Reset mid-grant SHALL drop gnt immediately, and no value SHALL be delivered.
REQ-029 Reset release SHALL take effect on the first rising clk edge after rst_n=1.

Configuration
REQ-030 With RAND_ARB_STATS_EN defined, an output grant_cnt[7:0] SHALL count grants, saturate at 255, clear on reset and clear while in LOAD.
REQ-031 Without RAND_ARB_STATS_EN, grant_cnt and its logic SHALL be absent, and the port list SHALL be as in REQ-004..REQ-011.

Structure
REQ-032 Package rand_arb_pkg SHALL hold the FSM state enum, the default SEED, the lock-up substitute value 3'b001 and the LFSR width.
REQ-033 The LFSR SHALL be a sub-module rand_lfsr (clk, rst_n, load, seed, adv, q), instantiated once.
REQ-034 The round-robin search SHALL be a function in the package, not a module.

Verification
REQ-035 Reset, then req=4'b0001 held for 8 cycles -> gnt=0001 every cycle, with q sequence 001,010,101,011,111,110,100,001.
REQ-036 req=4'b1111 held -> gnt order 0001,0010,0100,1000,0001, with q values 001,010,101,011,111.
REQ-037 load=1 for 2 cycles with seed=3'b110 while req=4'b0100 -> busy=1 and gnt=0 during load; after release, gnt=0100 with q=110, then 100.
REQ-038 load=1 with seed=3'b000 -> the first grant after release has q=001.
REQ-039 rst_n pulsed low during a grant cycle -> gnt drops to 0 at once, and the next grant has q=SEED and goes to index 0.
REQ-040 With RAND_ARB_STATS_EN defined, 300 grants -> grant_cnt=255; then load pulse -> grant_cnt=0.
